// File: rtl/fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_buffer_if
// Groups the signals between the instruction-fetch front end, the instruction
// memory, the later pipeline stages (redirect) and the ID stage.
//
// Signals:
//   ImemReqValid  fetch request valid              (fetch -> imem)
//   ImemReqReady  memory accepts request           (imem  -> fetch)
//   ImemAddr      word-aligned fetch address       (fetch -> imem)
//   ImemRespValid instruction word returned        (imem  -> fetch)
//   ImemRespData  returned instruction word        (imem  -> fetch)
//   Redirect      flush and restart at RedirectPC  (EX/MEM -> fetch)
//   RedirectPC    new fetch address, [1:0] ignored (EX/MEM -> fetch)
//   StallD        ID stage holding its input       (ID -> fetch)
//   InstrValidD   head entry valid                 (fetch -> ID)
//   InstrD        head instruction                 (fetch -> ID)
//   PCD           PC of head instruction           (fetch -> ID)
//
// Modports:
//   master  the fetch_buffer side
//   slave   the environment (memory, redirect source, ID stage)
// -----------------------------------------------------------------------------
interface fetch_buffer_if;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        StallD;
    logic        InstrValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;

    modport master (
        output ImemReqValid,
        output ImemAddr,
        output InstrValidD,
        output InstrD,
        output PCD,
        input  ImemReqReady,
        input  ImemRespValid,
        input  ImemRespData,
        input  Redirect,
        input  RedirectPC,
        input  StallD
    );

    modport slave (
        input  ImemReqValid,
        input  ImemAddr,
        input  InstrValidD,
        input  InstrD,
        input  PCD,
        output ImemReqReady,
        output ImemRespValid,
        output ImemRespData,
        output Redirect,
        output RedirectPC,
        output StallD
    );
endinterface

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Instruction-fetch front end. Owns the fetch PC, issues one-outstanding
// requests to instruction memory and queues returned instructions together
// with their PCs for the ID stage. A redirect flushes the queue, restarts
// fetch at the new PC and squashes a fetch that is still in flight.
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   CPU_CLK   clock, rising edge
//   CPU_RST   asynchronous active-high reset
//   bus       fetch_buffer_if.master (memory channel, redirect, ID handshake)
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           CPU_CLK,
    input  logic           CPU_RST,
    fetch_buffer_if.master bus
);
    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [29:0]      RESET_WORD = RESET_PC[31:2];

    // PCs are held as word addresses; the low two bits are always zero.
    logic [29:0]      fetch_pc_q, fetch_pc_d;
    logic [29:0]      pend_pc_q,  pend_pc_d;
    logic             pending_q,  pending_d;
    logic             discard_q,  discard_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic [29:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic             head_valid;
    logic [CNT_W-1:0] occupancy;
    logic             req_valid;
    logic             accept;
    logic             resp;
    logic             push;
    logic             pop;

    // RedirectPC[1:0] is deliberately ignored.
    logic             unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.RedirectPC[1:0];

    always_comb begin
        head_valid = (count_q != '0);
        // An accepted-but-unanswered request already owns a queue slot, so a
        // returning instruction can always be written without back-pressure.
        occupancy  = count_q + CNT_W'(pending_q);
        // A response arriving this cycle frees the outstanding slot, which
        // lets back-to-back fetches run at one per cycle.
        req_valid  = !CPU_RST && !bus.Redirect
                     && (!pending_q || bus.ImemRespValid)
                     && (occupancy < DEPTH_C);
        accept     = req_valid && bus.ImemReqReady;
        // Responses with nothing outstanding are protocol errors and ignored.
        resp       = bus.ImemRespValid && pending_q;
        push       = resp && !discard_q && !bus.Redirect;
        pop        = head_valid && !bus.StallD && !bus.Redirect;

        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = pending_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (accept) begin
            pend_pc_d = fetch_pc_q;
            pending_d = 1'b1;
        end else if (resp) begin
            pending_d = 1'b0;
        end

        // The squash marker is consumed by the response it refers to; it is
        // only needed when the redirect arrives before that response does.
        if (resp) begin
            discard_d = 1'b0;
        end else if (bus.Redirect && pending_q) begin
            discard_d = 1'b1;
        end

        if (bus.Redirect) begin
            fetch_pc_d = bus.RedirectPC[31:2];
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 30'd1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            fetch_pc_q <= RESET_WORD;
            pend_pc_q  <= RESET_WORD;
            pending_q  <= 1'b0;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries no reset; only entries below count are visible.
    always_ff @(posedge CPU_CLK) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= pend_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.ImemRespData;
        end
    end

    assign bus.ImemReqValid = req_valid;
    assign bus.ImemAddr     = {fetch_pc_q, 2'b00};
    assign bus.InstrValidD  = head_valid;
    assign bus.InstrD       = instr_mem_q[rd_ptr_q];
    assign bus.PCD          = {pc_mem_q[rd_ptr_q], 2'b00};

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
// Self-checking bench for fetch_buffer. A reference model built from a queue
// of {pc, instr} records and one in-flight request record predicts the
// outputs every cycle; directed scenarios add literal expectations, followed
// by a randomized run with a variable-latency memory.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic CPU_CLK = 1'b0;
    logic CPU_RST = 1'b0;

    fetch_buffer_if bus();

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CPU_CLK (CPU_CLK),
        .CPU_RST (CPU_RST),
        .bus     (bus.master)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_fetch;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    bit          m_stale;

    // Memory model state
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_data;
    int          lat_cfg;
    bit          force_stray;

    // Stimulus for the current cycle
    bit          rdy;
    bit          stall;
    bit          redir;
    logic [31:0] redir_pc;

    // DUT outputs sampled mid-cycle
    logic        s_req;
    logic        s_vld;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    bit          s_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fetch   = {RESET_PC[31:2], 2'b00};
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        m_stale   = 1'b0;
        mem_busy  = 1'b0;
        mem_wait  = 0;
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the
    // model to the state after the next rising edge.
    task automatic step();
        bit          resp_v;
        bit          from_mem;
        bit          exp_req;
        bit          resp;
        bit          pop;
        logic [31:0] resp_d;
        int          lat;

        from_mem = 1'b0;
        if (force_stray) begin
            resp_v = 1'b1;
            resp_d = 32'hDEAD_BEEF;
        end else if (mem_busy && mem_wait == 0) begin
            resp_v   = 1'b1;
            resp_d   = mem_data;
            from_mem = 1'b1;
        end else begin
            resp_v = 1'b0;
            resp_d = $urandom;
        end
        bus.ImemReqReady  = rdy;
        bus.StallD        = stall;
        bus.Redirect      = redir;
        bus.RedirectPC    = redir_pc;
        bus.ImemRespValid = resp_v;
        bus.ImemRespData  = resp_d;

        @(negedge CPU_CLK);
        s_req   = bus.ImemReqValid;
        s_vld   = bus.InstrValidD;
        s_addr  = bus.ImemAddr;
        s_pc    = bus.PCD;
        s_instr = bus.InstrD;

        exp_req = !CPU_RST && !redir && (!m_infl || resp_v)
                  && (q.size() + int'(m_infl) < DEPTH);
        chk("req_valid", 32'(s_req), 32'(exp_req));
        chk("imem_addr", s_addr, m_fetch);
        chk("instr_valid", 32'(s_vld), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("pcd", s_pc, q[0].pc);
            chk("instrd", s_instr, q[0].instr);
        end

        s_acc = exp_req && rdy;
        if (!CPU_RST) begin
            resp = resp_v && m_infl;
            pop  = (q.size() != 0) && !stall && !redir;
            if (redir) begin
                q.delete();
                if (resp) begin
                    m_infl  = 1'b0;
                    m_stale = 1'b0;
                end else if (m_infl) begin
                    m_stale = 1'b1;
                end
                m_fetch = {redir_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(q.pop_front());
                if (resp) begin
                    if (!m_stale) q.push_back('{m_infl_pc, resp_d});
                    m_infl  = 1'b0;
                    m_stale = 1'b0;
                end
                if (s_acc) begin
                    m_infl    = 1'b1;
                    m_infl_pc = m_fetch;
                    m_stale   = 1'b0;
                    m_fetch   = m_fetch + 32'd4;
                end
            end
            if (q.size() > DEPTH) begin
                chk("model_overflow", 32'(q.size()), 32'(DEPTH));
            end
        end

        if (CPU_RST) begin
            mem_busy = 1'b0;
        end else begin
            if (from_mem) mem_busy = 1'b0;
            else if (mem_busy && mem_wait > 0) mem_wait--;
            if (s_acc) begin
                lat      = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                mem_busy = 1'b1;
                mem_wait = lat - 1;
                mem_data = $urandom;
            end
        end

        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic do_reset();
        CPU_RST = 1'b1;
        #1;
        chk("rst_instr_valid", 32'(bus.InstrValidD), 32'h0);
        chk("rst_req_valid", 32'(bus.ImemReqValid), 32'h0);
        model_reset();
        step();
        step();
        CPU_RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_cnt;
        bit  seen_req;
        bit  seen_vld;

        rdy = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        lat_cfg = 1; force_stray = 1'b0;
        bus.ImemReqReady = 1'b0; bus.StallD = 1'b0; bus.Redirect = 1'b0;
        bus.RedirectPC = 32'h0; bus.ImemRespValid = 1'b0; bus.ImemRespData = 32'h0;
        #2;

        // Streaming from reset with a one-cycle memory
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            if (c < 4) begin
                chk("t1_req", 32'(s_req), 32'h1);
                chk("t1_addr", s_addr, 32'(4 * c));
            end
            if (c == 1) chk("t1_vld_early", 32'(s_vld), 32'h0);
            if (c >= 2) begin
                chk("t1_vld", 32'(s_vld), 32'h1);
                chk("t1_pcd", s_pc, 32'(4 * (c - 2)));
            end
        end

        // Stalled ID fills the queue, then drains in order
        do_reset();
        stall = 1'b1; acc_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (s_req && rdy) acc_cnt++;
            if (c >= 2) chk("t2_head_pc", s_pc, 32'h0);
        end
        chk("t2_accepts", 32'(acc_cnt), 32'd4);
        chk("t2_req_low", 32'(s_req), 32'h0);
        stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t2_drain_pc", s_pc, 32'(4 * c));
            if (c == 0) chk("t2_req_still_low", 32'(s_req), 32'h0);
            if (c == 1) begin
                chk("t2_resume_req", 32'(s_req), 32'h1);
                chk("t2_resume_addr", s_addr, 32'd16);
            end
        end

        // Memory not ready: request holds, advances once on accept
        do_reset();
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_hold_req", 32'(s_req), 32'h1);
            chk("t3_hold_addr", s_addr, 32'h0);
        end
        rdy = 1'b1;
        step();
        chk("t3_accept_addr", s_addr, 32'h0);
        step();
        chk("t3_next_addr", s_addr, 32'h4);
        step();
        chk("t3_next2_addr", s_addr, 32'h8);

        // Redirect while a 3-cycle fetch is outstanding
        do_reset();
        lat_cfg = 3; stall = 1'b1;
        for (int c = 0; c < 7; c++) step();
        redir = 1'b1; redir_pc = 32'h0000_0103;
        step();
        chk("t4_old_head_vld", 32'(s_vld), 32'h1);
        chk("t4_old_head_pc", s_pc, 32'h0);
        chk("t4_no_req_redirect", 32'(s_req), 32'h0);
        redir = 1'b0; stall = 1'b0;
        step();
        chk("t4_flushed", 32'(s_vld), 32'h0);
        seen_req = 1'b0; seen_vld = 1'b0;
        for (int c = 0; c < 20 && !seen_vld; c++) begin
            step();
            if (s_req && !seen_req) begin
                seen_req = 1'b1;
                chk("t4_new_addr", s_addr, 32'h0000_0100);
            end
            if (s_vld && !seen_vld) begin
                seen_vld = 1'b1;
                chk("t4_new_pcd", s_pc, 32'h0000_0100);
            end
        end
        if (!seen_vld) chk("t4_timeout", 32'h0, 32'h1);

        // Redirect coinciding with the response
        do_reset();
        lat_cfg = 2;
        step();
        step();
        redir = 1'b1; redir_pc = 32'h0000_0040;
        step();
        chk("t5_no_req_redirect", 32'(s_req), 32'h0);
        redir = 1'b0;
        step();
        chk("t5_req", 32'(s_req), 32'h1);
        chk("t5_addr", s_addr, 32'h0000_0040);
        chk("t5_dropped", 32'(s_vld), 32'h0);
        seen_vld = 1'b0;
        for (int c = 0; c < 10 && !seen_vld; c++) begin
            step();
            if (s_vld) begin
                seen_vld = 1'b1;
                chk("t5_pcd", s_pc, 32'h0000_0040);
            end
        end
        if (!seen_vld) chk("t5_timeout", 32'h0, 32'h1);

        // Reset pulsed with a full queue, then a stray response
        do_reset();
        lat_cfg = 1; stall = 1'b1;
        for (int c = 0; c < 8; c++) step();
        chk("t6_full_vld", 32'(s_vld), 32'h1);
        chk("t6_full_req", 32'(s_req), 32'h0);
        do_reset();
        force_stray = 1'b1;
        step();
        force_stray = 1'b0;
        chk("t6_restart_req", 32'(s_req), 32'h1);
        chk("t6_restart_addr", s_addr, RESET_PC);
        step();
        chk("t6_stray_ignored", 32'(s_vld), 32'h0);
        chk("t6_addr4", s_addr, 32'h4);
        step();
        chk("t6_first_pc", s_pc, RESET_PC);
        stall = 1'b0;

        // Randomized traffic
        lat_cfg = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            rdy      = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            stall    = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            redir    = ($urandom_range(0, 23) == 0);
            redir_pc = $urandom;
            step();
        end
        redir = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
